dmux_router: RTL and testbench
==============================

DMUX_ROUTER -- requirements
Module: dmux_router

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (1..64).
REQ-002 Parameter CHANNELS, default 4, number of output channels (2..16).
REQ-003 Derived localparam SELW = $clog2(CHANNELS)+1, width of the select field.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  input word present.
REQ-007 in_ready  output  1  block accepts the input word this cycle.
REQ-008 in_data  input  WIDTH  input word.
REQ-009 in_sel  input  SELW  destination channel index.
REQ-010 out_valid  output  CHANNELS  per-channel word present; bit i belongs to channel i.
REQ-011 out_ready  input  CHANNELS  per-channel consumer ready.
REQ-012 out_data  output  CHANNELS*WIDTH  per-channel word; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-013 drop_cnt  output  8  count of discarded words, saturating.

Function
REQ-014 Each channel has one output holding register (slot), either EMPTY or FULL; out_valid[i] = slot i FULL.
REQ-015 An input transfer is in_valid & in_ready sampled at a rising edge; an output transfer on channel i is out_valid[i] & out_ready[i].
REQ-016 For in_sel < CHANNELS: in_ready = slot in_sel EMPTY, or slot in_sel FULL with out_ready[in_sel] high (same-cycle drain and refill).
REQ-017 An accepted word appears on out_data of channel in_sel, with out_valid set, one cycle after acceptance; no combinational path from in_data to out_data.
REQ-018 A slot becomes EMPTY after an output transfer unless it is refilled in the same cycle; refill takes priority and leaves the slot FULL with the new word.
REQ-019 out_data of an EMPTY channel is all zeros; unselected channels never change on an input transfer.
REQ-020 While out_valid[i] is high and out_ready[i] is low, out_data and out_valid of channel i are held stable.
REQ-021 in_ready depends only on in_sel, slot state and out_ready; it never depends on in_valid.
REQ-022 Word order is preserved per channel; the block has no cross-channel ordering guarantee.
REQ-023 Any mix of channels may drain in the same cycle, independently of each other and of the input side.

Reset
REQ-024 rst_n low asynchronously forces every slot EMPTY, out_valid = 0, out_data = 0 and drop_cnt = 0, even mid-transfer.
REQ-025 While rst_n is low, in_ready = 0.
REQ-026 The first input transfer occurs no earlier than the first rising edge after rst_n deasserts; words held at reset are lost and are not counted.

Configuration
REQ-027 Macro DMUX_ROUTER_BCAST_EN selects how an out-of-range select (in_sel >= CHANNELS) is handled.
REQ-028 Without the macro: in_ready = 1, the word is discarded and drop_cnt increments, saturating at 255.
REQ-029 With the macro: the word is broadcast to all CHANNELS slots. in_ready = 1 only when every slot is EMPTY or draining this cycle. All slots fill on the same edge. drop_cnt stays 0.

Verification
REQ-030 Reset, then in_sel=2, in_data=8'hA5, in_valid=1 for one cycle, all out_ready=1 -> next cycle out_valid=4'b0100 and channel 2 data 8'hA5; all other channels 0; one cycle later out_valid=0.
REQ-031 out_ready[1]=0; send 8'h11 then 8'h22 to channel 1 -> 8'h11 is held; in_ready=0 for the second word; raise out_ready[1] -> 8'h11 transfers, and 8'h22 is accepted in the same cycle and appears next cycle.
REQ-032 Back-to-back stream of 8'h00..8'h0F to channel 0 with out_ready[0]=1 -> in_ready stays high, one word per cycle, order preserved.
REQ-033 Without the macro: in_sel=5 with 300 valid words -> no out_valid pulses and drop_cnt=255. With DMUX_ROUTER_BCAST_EN: in_sel=5, data 8'h3C, all slots empty -> next cycle out_valid=4'hF and all channels 8'h3C.
REQ-034 Assert rst_n=0 asynchronously between edges while channels 0 and 3 are full -> out_valid=0, out_data=0 and drop_cnt=0 immediately; no transfer occurs until the first edge after release.

Source files
------------

// File: rtl/dmux_router.sv
// One-deep registered demultiplexer: routes each input word to the holding slot of channel in_sel.
// Build option DMUX_ROUTER_BCAST_EN: out-of-range selects broadcast to every slot instead of being dropped.
module dmux_router #(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  localparam int SELW     = $clog2(CHANNELS) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SELW-1:0]           in_sel,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [7:0]                drop_cnt
);

`ifdef DMUX_ROUTER_BCAST_EN
  localparam logic BCAST_C = 1'b1;
`else
  localparam logic BCAST_C = 1'b0;
`endif

  logic [CHANNELS-1:0]       full_r;
  logic [CHANNELS*WIDTH-1:0] data_r;
  logic [7:0]                drop_r;

  logic [CHANNELS-1:0]       room_s;
  logic [CHANNELS-1:0]       load_s;
  logic [CHANNELS-1:0]       full_nxt_s;
  logic [CHANNELS*WIDTH-1:0] data_nxt_s;
  logic [7:0]                drop_nxt_s;
  logic                      in_range_s;
  logic                      sel_room_s;
  logic                      oor_room_s;
  logic                      ready_s;
  logic                      accept_s;

  // Acceptance: a slot has room when it is empty or drains this cycle; in_valid is never consulted.
  always_comb begin
    room_s     = ~full_r | out_ready;
    in_range_s = (in_sel < SELW'(CHANNELS));
    sel_room_s = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      sel_room_s = (in_sel == SELW'(i)) ? room_s[i] : sel_room_s;
    end
    oor_room_s = BCAST_C ? (&room_s) : 1'b1;
    ready_s    = rst_n & (in_range_s ? sel_room_s : oor_room_s);
    accept_s   = in_valid & ready_s;
  end

  // Slot next state: refill wins over drain, and an emptied slot presents zeros.
  always_comb begin
    load_s     = '0;
    full_nxt_s = '0;
    data_nxt_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      load_s[i]     = accept_s & (in_range_s ? (in_sel == SELW'(i)) : BCAST_C);
      full_nxt_s[i] = load_s[i] | (full_r[i] & ~out_ready[i]);
      if (load_s[i]) begin
        data_nxt_s[i*WIDTH +: WIDTH] = in_data;
      end else if (full_r[i] & ~out_ready[i]) begin
        data_nxt_s[i*WIDTH +: WIDTH] = data_r[i*WIDTH +: WIDTH];
      end else begin
        data_nxt_s[i*WIDTH +: WIDTH] = {WIDTH{1'b0}};
      end
    end
  end

  // Saturating count of discarded out-of-range words.
  always_comb begin
    if (accept_s & ~in_range_s & ~BCAST_C & (drop_r != 8'hFF)) begin
      drop_nxt_s = drop_r + 8'd1;
    end else begin
      drop_nxt_s = drop_r;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_r <= '0;
      data_r <= '0;
      drop_r <= 8'd0;
    end else begin
      full_r <= full_nxt_s;
      data_r <= data_nxt_s;
      drop_r <= drop_nxt_s;
    end
  end

  assign in_ready  = ready_s;
  assign out_valid = full_r;
  assign out_data  = data_r;
  assign drop_cnt  = drop_r;

endmodule

// File: tb/tb_dmux_router.sv
// Self-checking bench for dmux_router (WIDTH=8, CHANNELS=4): vector table, corner sequences, random vs. queue model.
module tb_dmux_router;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic [2:0]  in_sel = 3'd0;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = 4'h0;
  logic [31:0] out_data;
  logic [7:0]  drop_cnt;

  int n_pass = 0;
  int n_chk  = 0;

`ifdef DMUX_ROUTER_BCAST_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  dmux_router #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        v;
    logic [2:0]  sel;
    logic [7:0]  d;
    logic [3:0]  ordy;
    logic        exp_rdy;
    logic [3:0]  exp_valid;
    logic [31:0] exp_data;
    logic [7:0]  exp_drop;
  } vec_t;

  vec_t tbl [13];

  // Reference model: each channel is a queue holding at most one word.
  logic [7:0] mq [4][$];
  int         mdrop;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_sel = 3'd0; in_data = 8'h00; out_ready = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic [7:0] d, input logic [3:0] r);
    in_valid = v; in_sel = s; in_data = d; out_ready = r;
  endtask

  function automatic vec_t mk(input logic v, input logic [2:0] s, input logic [7:0] d, input logic [3:0] r,
                              input logic er, input logic [3:0] ev, input logic [31:0] ed, input logic [7:0] edr);
    vec_t t;
    t.v = v; t.sel = s; t.d = d; t.ordy = r;
    t.exp_rdy = er; t.exp_valid = ev; t.exp_data = ed; t.exp_drop = edr;
    return t;
  endfunction

  logic        exp_rdy;
  logic [3:0]  exp_valid;
  logic [31:0] exp_data;
  logic        pulsed;

  initial begin
    logic [7:0] d1;
    d1 = BC ? 8'd0 : 8'd1;
    tbl[0]  = mk(1'b1, 3'd2, 8'hA5, 4'hF, 1'b1, 4'b0100, 32'h00A5_0000, 8'd0);
    tbl[1]  = mk(1'b0, 3'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 32'h0000_0000, 8'd0);
    tbl[2]  = mk(1'b1, 3'd1, 8'h11, 4'hD, 1'b1, 4'b0010, 32'h0000_1100, 8'd0);
    tbl[3]  = mk(1'b1, 3'd1, 8'h22, 4'hD, 1'b0, 4'b0010, 32'h0000_1100, 8'd0);
    tbl[4]  = mk(1'b1, 3'd1, 8'h22, 4'hF, 1'b1, 4'b0010, 32'h0000_2200, 8'd0);
    tbl[5]  = mk(1'b0, 3'd1, 8'h00, 4'hF, 1'b1, 4'b0000, 32'h0000_0000, 8'd0);
    if (BC) tbl[6] = mk(1'b1, 3'd5, 8'h77, 4'hF, 1'b1, 4'b1111, 32'h7777_7777, 8'd0);
    else    tbl[6] = mk(1'b1, 3'd5, 8'h77, 4'hF, 1'b1, 4'b0000, 32'h0000_0000, 8'd1);
    tbl[7]  = mk(1'b0, 3'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 32'h0000_0000, d1);
    tbl[8]  = mk(1'b1, 3'd0, 8'h5A, 4'h0, 1'b1, 4'b0001, 32'h0000_005A, d1);
    tbl[9]  = mk(1'b1, 3'd3, 8'hC3, 4'h0, 1'b1, 4'b1001, 32'hC300_005A, d1);
    tbl[10] = mk(1'b1, 3'd0, 8'h99, 4'h0, 1'b0, 4'b1001, 32'hC300_005A, d1);
    tbl[11] = mk(1'b0, 3'd0, 8'h00, 4'h1, 1'b1, 4'b1000, 32'hC300_0000, d1);
    tbl[12] = mk(1'b0, 3'd3, 8'h00, 4'hF, 1'b1, 4'b0000, 32'h0000_0000, d1);

    // Reset state.
    in_valid = 1'b1; in_sel = 3'd0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    do_reset();
    chk("rst_out_valid", {28'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);

    // Vector table.
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].ordy);
      #1;
      chk($sformatf("tbl%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].exp_rdy});
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_out_valid", i), {28'd0, out_valid}, {28'd0, tbl[i].exp_valid});
      chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].exp_data);
      chk($sformatf("tbl%0d_drop_cnt", i), {24'd0, drop_cnt}, {24'd0, tbl[i].exp_drop});
    end

    // Back-to-back stream into channel 0.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 3'd0, 8'(k), 4'h1);
      #1;
      chk($sformatf("stream%0d_in_ready", k), {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("stream%0d_data", k), {out_valid, out_data[7:0]}, {20'd0, 4'b0001, 8'(k)});
    end
    drive(1'b0, 3'd0, 8'h00, 4'h1);
    @(posedge clk);
    #1;
    chk("stream_drained", {28'd0, out_valid}, 32'd0);

    // Out-of-range select.
    do_reset();
    if (BC) begin
      drive(1'b1, 3'd5, 8'h3C, 4'h0);
      @(posedge clk);
      #1;
      chk("bcast_valid", {28'd0, out_valid}, 32'h0000_000F);
      chk("bcast_data", out_data, 32'h3C3C_3C3C);
      chk("bcast_drop", {24'd0, drop_cnt}, 32'd0);
    end else begin
      pulsed = 1'b0;
      for (int k = 0; k < 300; k++) begin
        drive(1'b1, 3'd5, 8'(k), 4'hF);
        @(posedge clk);
        #1;
        pulsed = pulsed | (|out_valid);
      end
      chk("drop_no_pulse", {31'd0, pulsed}, 32'd0);
      chk("drop_saturate", {24'd0, drop_cnt}, 32'd255);
    end

    // Asynchronous reset mid-transfer with channels 0 and 3 full.
    do_reset();
    drive(1'b1, 3'd5, 8'hEE, 4'h0);
    @(posedge clk); #1;
    drive(1'b1, 3'd0, 8'h10, 4'h0);
    @(posedge clk); #1;
    drive(1'b1, 3'd3, 8'h13, 4'h0);
    @(posedge clk); #1;
    chk("pre_arst_valid", {28'd0, out_valid}, BC ? 32'h0000_000F : 32'h0000_0009);
    drive(1'b1, 3'd0, 8'h44, 4'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {28'd0, out_valid}, 32'd0);
    chk("arst_data", out_data, 32'd0);
    chk("arst_drop", {24'd0, drop_cnt}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 4'hF;
    @(posedge clk); #1;
    chk("arst_hold_valid", {28'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_no_xfer", {28'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("release_first_xfer", {out_valid, out_data}, {24'd0, 4'b0001, 32'h0000_0044});

    // Randomised traffic against the queue model.
    do_reset();
    for (int c = 0; c < 4; c++) mq[c].delete();
    mdrop = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int r;
      logic room_all;
      r = int'($urandom_range(0, 9));
      drive(1'($urandom), (r < 8) ? 3'(r % 4) : 3'($urandom_range(4, 7)), 8'($urandom), 4'($urandom));
      #1;
      room_all = 1'b1;
      for (int c = 0; c < 4; c++) room_all = room_all & ((mq[c].size() == 0) | out_ready[c]);
      if (in_sel < 3'd4) exp_rdy = (mq[in_sel[1:0]].size() == 0) | out_ready[in_sel[1:0]];
      else exp_rdy = BC ? room_all : 1'b1;
      chk("rnd_in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      @(posedge clk);
      for (int c = 0; c < 4; c++)
        if (mq[c].size() != 0 && out_ready[c]) void'(mq[c].pop_front());
      if (in_valid && exp_rdy) begin
        if (in_sel < 3'd4) mq[in_sel[1:0]].push_back(in_data);
        else if (BC) for (int c = 0; c < 4; c++) mq[c].push_back(in_data);
        else if (mdrop < 255) mdrop++;
      end
      #1;
      for (int c = 0; c < 4; c++) begin
        exp_valid[c] = (mq[c].size() != 0);
        exp_data[c*8 +: 8] = (mq[c].size() != 0) ? mq[c][0] : 8'h00;
      end
      chk("rnd_out_valid", {28'd0, out_valid}, {28'd0, exp_valid});
      chk("rnd_out_data", out_data, exp_data);
      chk("rnd_drop_cnt", {24'd0, drop_cnt}, 32'(mdrop));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
